// File: rtl/magnetron_ctrl.sv
// Magnetron enable controller: IDLE/COOK/PAUSE FSM plus per-window duty cycling of mag_on.
// Latency: mag_on/cooking/paused follow inputs by 1 clk; door open or clear gates mag_on combinationally.
// Backpressure: none; level/edge button inputs are sampled every cycle and never stalled.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   startn                    start button, active-low, falling-edge triggered
//   stopn, clearn             stop/pause and clear buttons, active-low levels
//   door_closed, timer_done   door switch (1 = closed), countdown expiry level
//   power_level[PWR_W]        on-cycles per PERIOD-cycle window
//   mag_on, cooking, paused   magnetron enable, FSM state decodes
//   beep                      end-of-cook pulse, present only when MAG_BEEP_EN is defined
//
// Optional feature macro: MAG_BEEP_EN (end-of-cook beep counter).
module magnetron_ctrl #(
  parameter int PWR_W       = 4,
  parameter int PERIOD      = 8,
  parameter int BEEP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_level,
  output logic             mag_on,
  output logic             cooking,
  output logic             paused,
  output logic             beep
);

  localparam int PH_W  = $clog2(PERIOD);
  localparam int CMP_W = (PWR_W > PH_W) ? PWR_W : PH_W;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [PH_W-1:0]    phase, phase_next;
  logic [PWR_W-1:0]   pwr_q, pwr_next;
  logic               start_q;
  logic               mag_q, mag_next;
  logic               start_evt;
  logic [CMP_W-1:0]   phase_cmp, pwr_cmp;

  // One event per press: only the high-to-low transition of startn counts.
  assign start_evt = start_q & ~startn;

  always_comb begin
    next_state = state;
    if (!clearn || timer_done) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_evt && door_closed)          next_state = COOK;
        COOK:    if (!door_closed || !stopn)            next_state = PAUSE;
        PAUSE:   if (start_evt && door_closed && stopn) next_state = COOK;
        default:                                        next_state = IDLE;
      endcase
    end
  end

  // Phase restarts on every COOK entry; power level is sampled only at window
  // boundaries so a mid-window change never produces a truncated window.
  always_comb begin
    phase_next = '0;
    pwr_next   = pwr_q;
    if (next_state == COOK) begin
      if (state != COOK) begin
        phase_next = '0;
        pwr_next   = power_level;
      end else if (phase == PH_LAST) begin
        phase_next = '0;
        pwr_next   = power_level;
      end else begin
        phase_next = phase + 1'b1;
      end
    end
  end

  assign phase_cmp = CMP_W'(phase_next);
  assign pwr_cmp   = CMP_W'(pwr_next);
  assign mag_next  = (next_state == COOK) && (phase_cmp < pwr_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      pwr_q   <= '0;
      start_q <= 1'b1;
      mag_q   <= 1'b0;
    end else begin
      state   <= next_state;
      phase   <= phase_next;
      pwr_q   <= pwr_next;
      start_q <= startn;
      mag_q   <= mag_next;
    end
  end

  // Door and clear are safety interlocks: they cut the magnetron without
  // waiting for the next clock edge.
  assign mag_on  = mag_q & door_closed & clearn;
  assign cooking = (state == COOK);
  assign paused  = (state == PAUSE);

`ifdef MAG_BEEP_EN
  localparam int BC_W = $clog2(BEEP_CYCLES + 1);
  logic [BC_W-1:0] beep_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beep_cnt <= '0;
    end else if (!clearn) begin
      beep_cnt <= '0;
    end else if (timer_done && (state != IDLE)) begin
      beep_cnt <= BC_W'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign beep = (beep_cnt != '0);
`else
  // Keeps BEEP_CYCLES referenced when the beep counter is compiled out.
  logic [31:0] beep_unused;
  assign beep_unused = BEEP_CYCLES;
  assign beep        = 1'b0;
`endif

endmodule
